// File: rtl/hilo_unit.sv
// hilo_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// mul/mad/mt retire in one cycle; div is a 32-step restoring divider plus a
// single sign-fixup cycle, with busy covering the whole 33-cycle window.
module hilo_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  hilo_op,
  input  logic        unsgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  // 32 iteration cycles + 1 fixup cycle
  localparam int DIV_CYCLES = 33;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rem_q, rem_d;   // partial remainder
  logic [31:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic        done_q, done_d;

  // Operand sign handling shared by multiply and divide
  logic        sa, sb;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] abs_a, abs_b;
  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;

  // Datapath helpers: product, magnitudes, one restoring step, sign fixup
  always_comb begin
    sa    = ~unsgn & a[31];
    sb    = ~unsgn & b[31];
    ext_a = {{32{sa}}, a};
    ext_b = {{32{sb}}, b};
    // Low 64 bits of the extended product are exact for both signednesses
    prod  = ext_a * ext_b;
    abs_a = sa ? (~a + 32'd1) : a;
    abs_b = sb ? (~b + 32'd1) : b;
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    q_fix = qneg_q ? (~quo_q + 32'd1) : quo_q;
    r_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;
  end

  // Next-state and register updates for the op sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (hilo_op[1:0])
            2'd0: {hi_d, lo_d} = prod;
            2'd1: {hi_d, lo_d} = {hi_q, lo_q} + prod;
            2'd2: begin
              if (hilo_op[2]) hi_d = a;
              else            lo_d = a;
            end
            default: begin
              state_d = S_ITER;
              cnt_d   = 5'd0;
              rem_d   = 32'd0;
              quo_d   = abs_a;
              dvs_d   = abs_b;
              qneg_d  = sa ^ sb;
              rneg_d  = sa;
              dz_d    = (b == 32'd0);
            end
          endcase
        end
      end
      S_ITER: begin
        // trial[32] set means the subtraction borrowed: restore
        rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_CYCLES - 2)) state_d = S_FIX;
      end
      S_FIX: begin
        // With b=0 the divider leaves |a| in rem, so the sign fix restores a
        lo_d    = dz_q ? 32'hFFFF_FFFF : q_fix;
        hi_d    = r_fix;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, async active-low clear aborts any divide in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed + random checks of hilo_unit against an
// arithmetic reference model of HI/LO.
module tb_hilo_unit;

  logic        clk, reset_n, start, unsgn;
  logic [2:0]  hilo_op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  hilo_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hilo_op(hilo_op),
    .unsgn(unsgn), .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference divide from plain integer arithmetic
  task automatic ref_div(input logic u, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el);
    longint sa, sbv, q, r;
    if (bv == 32'd0) begin
      el = 32'hFFFF_FFFF;
      eh = av;
    end else if (u) begin
      el = av / bv;
      eh = av % bv;
    end else begin
      sa  = longint'($signed(av));
      sbv = longint'($signed(bv));
      q   = sa / sbv;
      r   = sa % sbv;
      el  = q[31:0];
      eh  = r[31:0];
    end
  endtask

  // Divide with busy-length, hold and done checks; ends in the done cycle
  task automatic run_div(input logic u, input logic [31:0] av, input logic [31:0] bv,
                         input bit glitch);
    logic [31:0] eh, el;
    int n;
    ref_div(u, av, bv, eh, el);
    start = 1'b1; hilo_op = 3'b011; unsgn = u; a = av; b = bv;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      chk("div_hold", {hi, lo}, {mhi, mlo});
      chk("div_nodone", {63'd0, done}, 64'd0);
      if (glitch && n == 5) begin
        start = 1'b1; hilo_op = 3'b000; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("div_busy_len", 64'(n), 64'd33);
    chk("div_done", {63'd0, done}, 64'd1);
    mhi = eh; mlo = el;
    chk("div_result", {hi, lo}, {mhi, mlo});
  endtask

  // One-cycle op (or divide) against the model
  task automatic do_op(input logic [2:0] op, input logic u, input logic [31:0] av,
                       input logic [31:0] bv);
    logic [63:0] p;
    if (op[1:0] == 2'd3) begin
      run_div(u, av, bv, 1'b0);
      return;
    end
    p = u ? ({32'd0, av} * {32'd0, bv})
          : 64'(longint'($signed(av)) * longint'($signed(bv)));
    case (op[1:0])
      2'd0: {mhi, mlo} = p;
      2'd1: {mhi, mlo} = {mhi, mlo} + p;
      default: if (op[2]) mhi = av; else mlo = av;
    endcase
    start = 1'b1; hilo_op = op; unsgn = u; a = av; b = bv;
    tick();
    start = 1'b0;
    chk("op_result", {hi, lo}, {mhi, mlo});
    chk("op_busy", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset_n = 1'b0; start = 1'b0; hilo_op = 3'd0; unsgn = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Reset in the 10th busy cycle of a divide
    do_op(3'b110, 1'b0, 32'h1111_1111, 32'd0);
    start = 1'b1; hilo_op = 3'b011; unsgn = 1'b1; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_div_busy", {63'd0, busy}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    mhi = 32'd0; mlo = 32'd0;
    #1 reset_n = 1'b1;
    do_op(3'b010, 1'b0, 32'd5, 32'd0);
    chk("mt_lo_5", {32'd0, lo}, 64'd5);

    // Multiply signed / unsigned
    do_op(3'b000, 1'b0, 32'hFFFF_FFFE, 32'd3);
    chk("mul_s", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(3'b000, 1'b1, 32'hFFFF_FFFE, 32'd3);
    chk("mul_u", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // Move-to then multiply-add with carry into HI
    do_op(3'b110, 1'b0, 32'd0, 32'd0);
    do_op(3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0);
    do_op(3'b001, 1'b1, 32'd1, 32'd1);
    chk("mad_carry", {hi, lo}, {32'd1, 32'd0});

    // Divides
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_s_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    chk("done_pulse", {63'd0, done}, 64'd0);
    run_div(1'b1, 32'd100, 32'd7, 1'b0);
    chk("div_u_100_7", {hi, lo}, {32'd2, 32'd14});
    run_div(1'b0, 32'd1234, 32'd0, 1'b0);
    chk("div_by_zero", {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

    // Start pulsed while busy, then mul issued in the done cycle
    run_div(1'b1, 32'd77, 32'd10, 1'b1);
    chk("div_glitch", {hi, lo}, {32'd7, 32'd7});
    do_op(3'b000, 1'b0, 32'd4, 32'd5);
    chk("b2b_mul", {hi, lo}, {32'd0, 32'd20});

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      do_op(rop, 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
